// File: rtl/ham_seq_unit.sv
// Multi-cycle Hamming weight / distance engine: latches one operand vector, then
// counts CHUNK bits per clock (LSB chunk first) into a running popcount.
`timescale 1ns/1ps

module ham_seq_unit #(
  parameter  int N     = 32,
  parameter  int CHUNK = 8,
  localparam int RW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          parity
);

  localparam int K  = N / CHUNK;
  localparam int CW = $clog2(CHUNK + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  generate
    if ((CHUNK < 1) || (N % CHUNK != 0)) begin : g_bad_chunk
      $error("ham_seq_unit: CHUNK must be positive and divide N");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    vec;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   acc;
  logic            accept;
  logic            last_chunk;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]   chunk_cnt;
  logic [RW-1:0]   acc_sum;

  function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] x);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c = c + CW'(x[i]);
    end
    return c;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_chunk) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign last_chunk = (idx == IW'(K - 1));
  assign chunk      = vec[idx * CHUNK +: CHUNK];
  assign chunk_cnt  = popcount(chunk);
  assign acc_sum    = acc + RW'(chunk_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec    <= '0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      parity <= 1'b0;
    end else if (accept) begin
      vec <= mode ? (a ^ b) : a;
      idx <= '0;
      acc <= '0;
    end else if (state == S_RUN) begin
      acc <= acc_sum;
      idx <= idx + 1'b1;
      // result/parity only move when the final chunk lands, and hold otherwise.
      if (last_chunk) begin
        result <= acc_sum;
        parity <= acc_sum[0];
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ham_seq_unit.sv
// Bench for ham_seq_unit: directed handshake cases on CHUNK=8, then random vectors
// run concurrently on CHUNK=8/1/32 instances against a $countones reference.
`timescale 1ns/1ps

module tb_ham_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  par_v;
  logic [5:0]  res_v [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: CHUNK=8 (K=4), instance 1: CHUNK=1 (K=32), instance 2: CHUNK=32 (K=1).
  ham_seq_unit #(.N(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .parity(par_v[0])
  );

  ham_seq_unit #(.N(32), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .parity(par_v[1])
  );

  ham_seq_unit #(.N(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .parity(par_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation on the CHUNK=8 instance with fixed-latency expectations.
  // Leaves the bench in the done cycle when leave==0, otherwise one cycle later.
  task automatic run_op(input string tag, input logic m, input logic [31:0] x,
                        input logic [31:0] y, input bit leave);
    int e;
    e = $countones(m ? (x ^ y) : x);
    mode = m; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      check($sformatf("%s_busy%0d", tag, t), busy_v[0], 1);
      check($sformatf("%s_nodone%0d", tag, t), done_v[0], 0);
      mode = ~mode; a = $urandom; b = $urandom;
      tick();
    end
    check({tag, "_done"}, done_v[0], 1);
    check({tag, "_idlebusy"}, busy_v[0], 0);
    check({tag, "_result"}, res_v[0], e);
    check({tag, "_parity"}, par_v[0], e & 1);
    if (leave) begin
      tick();
      check({tag, "_pulse"}, done_v[0], 0);
      check({tag, "_hold"}, res_v[0], e);
    end
  endtask

  initial begin
    int lat [3];
    int got [3];
    int gotp [3];
    int expk [3];
    int e;
    logic        m;
    logic [31:0] x;
    logic [31:0] y;

    expk = '{4, 32, 1};
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    tick();
    start = 1'b1;  // reset must override start
    tick();
    rst = 1'b0; start = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_busy%0d", d), busy_v[d], 0);
      check($sformatf("rst_done%0d", d), done_v[d], 0);
      check($sformatf("rst_result%0d", d), res_v[d], 0);
      check($sformatf("rst_parity%0d", d), par_v[d], 0);
    end

    // Weight of all ones, then distance cases.
    run_op("t1_ones", 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op("t2_dist32", 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
    run_op("t2_dist0", 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
    run_op("t2_dist1", 1'b1, 32'h0000_0001, 32'h0, 1'b1);

    // start held high and operands scrambled during RUN: one operation only.
    mode = 1'b0; a = 32'h0000_00FF; start = 1'b1;
    tick();
    for (int t = 1; t <= 4; t++) begin
      check($sformatf("t3_busy%0d", t), busy_v[0], 1);
      check($sformatf("t3_nodone%0d", t), done_v[0], 0);
      a = $urandom; b = $urandom; mode = ~mode;
      tick();
    end
    start = 1'b0;
    check("t3_done", done_v[0], 1);
    check("t3_result", res_v[0], 8);
    tick();
    check("t3_single_done", done_v[0], 0);
    check("t3_single_busy", busy_v[0], 0);

    // Back-to-back: start in the done cycle.
    run_op("t4_first", 1'b0, 32'h00FF_00FF, 32'h0, 1'b0);
    mode = 1'b0; a = 32'h0000_000F; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      check($sformatf("t4_busy%0d", t), busy_v[0], 1);
      check($sformatf("t4_nodone%0d", t), done_v[0], 0);
      check($sformatf("t4_hold%0d", t), res_v[0], 16);
      tick();
    end
    check("t4_done", done_v[0], 1);
    check("t4_result", res_v[0], 4);
    tick();

    // Reset during the second RUN cycle aborts the operation.
    mode = 1'b0; a = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy_v[0], 0);
    check("t5_done", done_v[0], 0);
    check("t5_result", res_v[0], 0);
    check("t5_parity", par_v[0], 0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check($sformatf("t5_nodone%0d", t), done_v[0], 0);
      check($sformatf("t5_zero%0d", t), res_v[0], 0);
    end
    run_op("t5_after", 1'b1, 32'h0000_FFFF, 32'h0000_00FF, 1'b1);

    // Random vectors on all three chunk widths at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int v = 0; v < 1000; v++) begin
      x = $urandom; y = $urandom; m = 1'($urandom_range(0, 1));
      if (v % 50 == 0) x = 32'hFFFF_FFFF;
      if (v % 50 == 1) begin x = 32'h0; y = 32'h0; end
      e = $countones(m ? (x ^ y) : x);
      mode = m; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      lat = '{-1, -1, -1};
      got = '{0, 0, 0};
      gotp = '{0, 0, 0};
      for (int t = 1; t <= 40; t++) begin
        a = $urandom; b = $urandom;
        tick();
        for (int d = 0; d < 3; d++) begin
          if (done_v[d] === 1'b1 && lat[d] < 0) begin
            lat[d] = t;
            got[d] = int'(res_v[d]);
            gotp[d] = int'(par_v[d]);
          end
        end
        if (lat[1] >= 0) break;
      end
      for (int d = 0; d < 3; d++) begin
        check($sformatf("rnd%0d_k%0d_lat", v, expk[d]), lat[d], expk[d]);
        check($sformatf("rnd%0d_k%0d_res", v, expk[d]), got[d], e);
        check($sformatf("rnd%0d_k%0d_par", v, expk[d]), gotp[d], e & 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
